tdm_demux: RTL

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux_if.sv | 24 ++
 rtl/tdm_demux.sv | 116 +++++++++++
 2 files changed

// File: rtl/tdm_demux_if.sv
// tdm_demux_if: bundle of the TDM receive link and its demultiplexed outputs.
//   master : drives serial_in / bit_valid / frame_sync, observes the lane outputs
//   slave  : the demultiplexer; samples the link and drives lane_data, lane_valid,
//            slot, locked and sync_error
interface tdm_demux_if;
  logic        serial_in;
  logic        bit_valid;
  logic        frame_sync;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic [1:0]  slot;
  logic        locked;
  logic        sync_error;

  modport master (
    output serial_in, bit_valid, frame_sync,
    input  lane_data, lane_valid, slot, locked, sync_error
  );

  modport slave (
    input  serial_in, bit_valid, frame_sync,
    output lane_data, lane_valid, slot, locked, sync_error
  );
endinterface

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a 4:1 bit-interleaved TDM link.
// A frame is 4 consecutive valid bits (slot k -> lane k); every lane byte is
// sent MSB first, one bit per frame, over 8 frames. frame_sync must mark each
// slot-0 bit and never appear on slots 1-3.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : tdm_demux_if.slave
//     serial_in/bit_valid/frame_sync : link inputs, qualified by bit_valid
//     lane_data[8i+7:8i] : last completed byte of lane i (held)
//     lane_valid[i]      : one-cycle pulse, lane i just completed
//     slot               : slot the next valid bit will be assigned to
//     locked             : 1 while frame alignment is held
//     sync_error         : one-cycle pulse on a framing violation
module tdm_demux (
  input  logic        clk,
  input  logic        reset,
  tdm_demux_if.slave  bus
);

  localparam int DATA_W = 8;
  localparam int LANES  = 4;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                          state_p1, state_d;
  logic [1:0]                      slot_p1, slot_d;
  logic [2:0]                      bit_cnt_p1, bit_cnt_d;
  logic [LANES-1:0][DATA_W-1:0]    shreg_p1, shreg_d;
  logic [LANES-1:0][DATA_W-1:0]    lane_p1, lane_d;
  logic [LANES-1:0]                vld_p1, vld_d;
  logic                            sync_err_p1, sync_err_d;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur,
                                                 input logic b);
    return {cur[DATA_W-2:0], b};
  endfunction

  // Next-state / output decode
  always_comb begin
    state_d    = state_p1;
    slot_d     = slot_p1;
    bit_cnt_d  = bit_cnt_p1;
    shreg_d    = shreg_p1;
    lane_d     = lane_p1;
    vld_d      = '0;
    sync_err_d = 1'b0;

    if (bus.bit_valid) begin
      if (state_p1 == HUNT) begin
        // Bits without frame_sync are dropped while hunting.
        if (bus.frame_sync) begin
          state_d   = LOCKED;
          shreg_d   = '0;
          shreg_d[0] = shift_in('0, bus.serial_in);
          slot_d    = 2'd1;
          bit_cnt_d = 3'd0;
        end
      end else begin
        if (bus.frame_sync && (slot_p1 != 2'd0)) begin
          // Early sync: realign on this bit as the new slot 0.
          sync_err_d = 1'b1;
          shreg_d    = '0;
          shreg_d[0] = shift_in('0, bus.serial_in);
          slot_d     = 2'd1;
          bit_cnt_d  = 3'd0;
        end else if (!bus.frame_sync && (slot_p1 == 2'd0)) begin
          // Missing sync: alignment lost, drop the bit and hunt again.
          sync_err_d = 1'b1;
          shreg_d    = '0;
          slot_d     = 2'd0;
          bit_cnt_d  = 3'd0;
          state_d    = HUNT;
        end else begin
          shreg_d[slot_p1] = shift_in(shreg_p1[slot_p1], bus.serial_in);
          if (bit_cnt_p1 == 3'd7) begin
            lane_d[slot_p1] = shift_in(shreg_p1[slot_p1], bus.serial_in);
            vld_d[slot_p1]  = 1'b1;
          end
          slot_d = slot_p1 + 2'd1;
          if (slot_p1 == 2'd3) begin
            bit_cnt_d = bit_cnt_p1 + 3'd1;
          end
        end
      end
    end
  end

  // Register stage: all outputs come straight from here
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1    <= HUNT;
      slot_p1     <= '0;
      bit_cnt_p1  <= '0;
      shreg_p1    <= '0;
      lane_p1     <= '0;
      vld_p1      <= '0;
      sync_err_p1 <= 1'b0;
    end else begin
      state_p1    <= state_d;
      slot_p1     <= slot_d;
      bit_cnt_p1  <= bit_cnt_d;
      shreg_p1    <= shreg_d;
      lane_p1     <= lane_d;
      vld_p1      <= vld_d;
      sync_err_p1 <= sync_err_d;
    end
  end

  assign bus.lane_data  = lane_p1;
  assign bus.lane_valid = vld_p1;
  assign bus.slot       = slot_p1;
  assign bus.locked     = (state_p1 == LOCKED);
  assign bus.sync_error = sync_err_p1;

endmodule
